ballot_input_frontend: RTL and testbench

Front-end stage for the voting machine. Conditions the raw board buttons (BTNU vote, BTNC finish, BTND reset) and slide switches (rep_sel, voter_id) and delivers clean single-cycle commands to the vote-counting core. Each vote press is validated for format: the voter ID must be 0–9 and exactly one representative must be selected. A ballot that passes is emitted as a qualified ballot. A ballot that fails is rejected with a reason code and a stretched LED indication. Duplicate-voter tracking stays in the counting core.

---
 rtl/voting_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/ballot_input_frontend.sv | 137 +++++++++++++
 tb/tb_ballot_input_frontend.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared constants, ballot FSM states and ballot format check
package voting_pkg;

    localparam logic [1:0] REJ_NONE = 2'b00;
    localparam logic [1:0] REJ_ID   = 2'b01;
    localparam logic [1:0] REJ_SEL  = 2'b10;
    localparam logic [1:0] REJ_BOTH = 2'b11;

    localparam int MAX_VOTER_ID = 9;
    localparam int NUM_REPS     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EVAL    = 2'd1,
        ST_HOLDOFF = 2'd2
    } ballot_state_t;

    // Bit 0 flags an out-of-range voter ID, bit 1 a selection that is not one-hot.
    function automatic logic [1:0] ballot_check(input logic [3:0] id,
                                                input logic [NUM_REPS-1:0] rep);
        logic id_bad;
        logic sel_bad;
        id_bad  = (id > 4'(MAX_VOTER_ID));
        sel_bad = ($countones(rep) != 1);
        return {sel_bad, id_bad};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, debounce counter and press pulse for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            // Press is registered one cycle after the stable level rises.
            press   <= level & ~level_q;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ballot_input_frontend.sv
// rtl/ballot_input_frontend.sv - button/switch conditioning and ballot format validation
module ballot_input_frontend
    import voting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int HOLDOFF_CYCLES     = 5_000_000,
    parameter int REJECT_HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnu_raw,
    input  logic       btnc_raw,
    input  logic       btnd_raw,
    input  logic [3:0] rep_sel_raw,
    input  logic [3:0] voter_id_raw,
    output logic       vote_valid,
    output logic [3:0] vote_id,
    output logic [3:0] vote_rep,
    output logic       finish_pulse,
    output logic       clear_pulse,
    output logic       reject_pulse,
    output logic [1:0] reject_code,
    output logic       reject_led,
    output logic       busy
);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int RW = $clog2(REJECT_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES);
    localparam logic [RW-1:0] REJ_LOAD  = RW'(REJECT_HOLD_CYCLES);

    logic [3:0]    rep_q1, rep_q2;
    logic [3:0]    id_q1, id_q2;
    logic          vote_level, vote_press, clear_press;
    logic          finish_level_unused, clear_level_unused;
    ballot_state_t state;
    logic [3:0]    lat_id, lat_rep;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rej_cnt;
    logic [1:0]    eval_code;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_vote (
        .clk(clk), .rst(rst), .btn_raw(btnu_raw),
        .level(vote_level), .press(vote_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_finish (
        .clk(clk), .rst(rst), .btn_raw(btnc_raw),
        .level(finish_level_unused), .press(finish_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst(rst), .btn_raw(btnd_raw),
        .level(clear_level_unused), .press(clear_press)
    );

    assign clear_pulse = clear_press;
    assign busy        = (state != ST_IDLE);
    assign reject_led  = (rej_cnt != '0);
    assign eval_code   = ballot_check(lat_id, lat_rep);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q1 <= '0;
            rep_q2 <= '0;
            id_q1  <= '0;
            id_q2  <= '0;
        end else begin
            rep_q1 <= rep_sel_raw;
            rep_q2 <= rep_q1;
            id_q1  <= voter_id_raw;
            id_q2  <= id_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            lat_id       <= '0;
            lat_rep      <= '0;
            hold_cnt     <= '0;
            rej_cnt      <= '0;
            vote_valid   <= 1'b0;
            vote_id      <= '0;
            vote_rep     <= '0;
            reject_pulse <= 1'b0;
            reject_code  <= REJ_NONE;
        end else begin
            vote_valid   <= 1'b0;
            vote_id      <= '0;
            vote_rep     <= '0;
            reject_pulse <= 1'b0;
            if (rej_cnt != '0) begin
                rej_cnt <= rej_cnt - RW'(1);
            end

            // A clear press wins over everything the FSM would do this cycle.
            if (clear_press) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
                rej_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (vote_press) begin
                            lat_id  <= id_q2;
                            lat_rep <= rep_q2;
                            state   <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        if (eval_code == REJ_NONE) begin
                            vote_valid <= 1'b1;
                            vote_id    <= lat_id;
                            vote_rep   <= lat_rep;
                        end else begin
                            reject_pulse <= 1'b1;
                            reject_code  <= eval_code;
                            rej_cnt      <= REJ_LOAD;
                        end
                        hold_cnt <= '0;
                        state    <= ST_HOLDOFF;
                    end
                    ST_HOLDOFF: begin
                        // Count saturates at the holdoff length, then wait for release.
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end else if (!vote_level) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ballot_input_frontend.sv
// tb/tb_ballot_input_frontend.sv - randomized self-checking bench for ballot_input_frontend
module tb_ballot_input_frontend;
    localparam int DB = 4;
    localparam int HO = 8;
    localparam int RH = 16;
    localparam int BALLOT_LAT = 2 + DB + 1 + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnu_raw = 1'b0, btnc_raw = 1'b0, btnd_raw = 1'b0;
    logic [3:0] rep_sel_raw = 4'd0, voter_id_raw = 4'd0;
    logic       vote_valid, finish_pulse, clear_pulse, reject_pulse, reject_led, busy;
    logic [3:0] vote_id, vote_rep;
    logic [1:0] reject_code;

    int checks = 0, errors = 0, cyc = 0;
    int n_vv = 0, t_vv = 0, id_vv = 0, rep_vv = 0;
    int n_rj = 0, t_rj = 0, code_rj = 0;
    int n_fin = 0, t_fin = 0, n_clr = 0, t_clr = 0, n_led = 0, n_busy = 0;
    int b_vv, b_rj, b_fin, b_clr, b_led, b_busy;
    int last_code = 0;

    ballot_input_frontend #(
        .DEBOUNCE_CYCLES(DB), .HOLDOFF_CYCLES(HO), .REJECT_HOLD_CYCLES(RH)
    ) dut (
        .clk(clk), .rst(rst),
        .btnu_raw(btnu_raw), .btnc_raw(btnc_raw), .btnd_raw(btnd_raw),
        .rep_sel_raw(rep_sel_raw), .voter_id_raw(voter_id_raw),
        .vote_valid(vote_valid), .vote_id(vote_id), .vote_rep(vote_rep),
        .finish_pulse(finish_pulse), .clear_pulse(clear_pulse),
        .reject_pulse(reject_pulse), .reject_code(reject_code),
        .reject_led(reject_led), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (vote_valid) begin
                n_vv <= n_vv + 1; t_vv <= cyc; id_vv <= int'(vote_id); rep_vv <= int'(vote_rep);
            end
            if (reject_pulse) begin
                n_rj <= n_rj + 1; t_rj <= cyc; code_rj <= int'(reject_code);
            end
            if (finish_pulse) begin n_fin <= n_fin + 1; t_fin <= cyc; end
            if (clear_pulse) begin n_clr <= n_clr + 1; t_clr <= cyc; end
            if (reject_led) n_led <= n_led + 1;
            if (busy) n_busy <= n_busy + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic snap();
        b_vv = n_vv; b_rj = n_rj; b_fin = n_fin; b_clr = n_clr; b_led = n_led; b_busy = n_busy;
    endtask

    function automatic int model_code(input int id, input int rep);
        int ones = 0;
        for (int b = 0; b < 4; b++) ones += (rep >> b) & 1;
        return ((ones != 1) ? 2 : 0) + ((id > 9) ? 1 : 0);
    endfunction

    // One vote press of len cycles, then enough idle time for holdoff, release and LED to finish.
    task automatic run_ballot(input string tag, input int id, input int rep, input int len);
        int t0, code;
        bit pressed;
        voter_id_raw = 4'(id);
        rep_sel_raw  = 4'(rep);
        ticks(3);
        snap();
        t0 = cyc;
        btnu_raw = 1'b1;
        ticks(len);
        btnu_raw = 1'b0;
        ticks(40);
        pressed = (len >= DB);
        code    = model_code(id, rep);
        chk({tag, "_vv_n"}, n_vv - b_vv, (pressed && code == 0) ? 1 : 0);
        chk({tag, "_rj_n"}, n_rj - b_rj, (pressed && code != 0) ? 1 : 0);
        chk({tag, "_led_n"}, n_led - b_led, (pressed && code != 0) ? RH : 0);
        if (pressed && code == 0) begin
            chk({tag, "_vv_t"}, t_vv, t0 + BALLOT_LAT);
            chk({tag, "_vv_id"}, id_vv, id);
            chk({tag, "_vv_rep"}, rep_vv, rep);
        end
        if (pressed && code != 0) begin
            chk({tag, "_rj_t"}, t_rj, t0 + BALLOT_LAT);
            chk({tag, "_rj_code"}, code_rj, code);
            last_code = code;
        end
        if (!pressed) chk({tag, "_busy_n"}, n_busy - b_busy, 0);
        chk({tag, "_code_hold"}, int'(reject_code), last_code);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int t0, id, rep, len;
        ticks(4);
        chk("rst_vote_valid", int'(vote_valid), 0);
        chk("rst_vote_id", int'(vote_id), 0);
        chk("rst_vote_rep", int'(vote_rep), 0);
        chk("rst_finish", int'(finish_pulse), 0);
        chk("rst_clear", int'(clear_pulse), 0);
        chk("rst_reject", int'(reject_pulse), 0);
        chk("rst_code", int'(reject_code), 0);
        chk("rst_led", int'(reject_led), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        ticks(5);

        run_ballot("t1", 3, 4'b0100, 20);
        run_ballot("t3", 12, 4'b0110, 6);

        for (int i = 0; i < 40; i++) begin
            id  = $urandom_range(0, 15);
            rep = ($urandom_range(0, 1) == 1) ? (1 << $urandom_range(0, 3)) : $urandom_range(0, 15);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB, 14);
            run_ballot($sformatf("r%0d", i), id, rep, len);
        end

        // Two short glitches
        snap();
        btnu_raw = 1'b1; ticks(DB - 1); btnu_raw = 1'b0; ticks(6);
        btnu_raw = 1'b1; ticks(DB - 1); btnu_raw = 1'b0; ticks(20);
        chk("t2_vv_n", n_vv - b_vv, 0);
        chk("t2_rj_n", n_rj - b_rj, 0);
        chk("t2_busy_n", n_busy - b_busy, 0);

        // Re-press during holdoff with the button held
        voter_id_raw = 4'd5; rep_sel_raw = 4'b0001; ticks(3);
        snap(); t0 = cyc;
        btnu_raw = 1'b1; ticks(5); btnu_raw = 1'b0; ticks(5);
        btnu_raw = 1'b1; ticks(30); btnu_raw = 1'b0; ticks(30);
        chk("t4_vv_n", n_vv - b_vv, 1);
        chk("t4_vv_t", t_vv, t0 + BALLOT_LAT);
        chk("t4_idle", int'(busy), 0);
        run_ballot("t4b", 5, 4'b0001, 6);

        // Clear press landing on the EVAL cycle
        voter_id_raw = 4'd2; rep_sel_raw = 4'b1000; ticks(3);
        snap(); t0 = cyc;
        btnu_raw = 1'b1; ticks(1); btnd_raw = 1'b1; ticks(8);
        btnu_raw = 1'b0; btnd_raw = 1'b0; ticks(30);
        chk("t5_clr_n", n_clr - b_clr, 1);
        chk("t5_clr_t", t_clr, t0 + BALLOT_LAT - 1);
        chk("t5_vv_n", n_vv - b_vv, 0);
        chk("t5_rj_n", n_rj - b_rj, 0);
        chk("t5_busy_n", n_busy - b_busy, 1);
        chk("t5_idle", int'(busy), 0);

        // Finish and vote together
        voter_id_raw = 4'd7; rep_sel_raw = 4'b0010; ticks(3);
        snap(); t0 = cyc;
        btnu_raw = 1'b1; btnc_raw = 1'b1; ticks(6);
        btnu_raw = 1'b0; btnc_raw = 1'b0; ticks(30);
        chk("t6_fin_n", n_fin - b_fin, 1);
        chk("t6_fin_t", t_fin, t0 + 2 + DB + 1);
        chk("t6_vv_n", n_vv - b_vv, 1);
        chk("t6_vv_t", t_vv, t0 + BALLOT_LAT);
        chk("t6_vv_id", id_vv, 7);

        // Asynchronous reset in the middle of holdoff after a reject
        voter_id_raw = 4'd12; rep_sel_raw = 4'b0110; ticks(3);
        t0 = cyc;
        btnu_raw = 1'b1; ticks(5); btnu_raw = 1'b0; ticks(7);
        chk("t7_pre_led", int'(reject_led), 1);
        chk("t7_pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t7_led", int'(reject_led), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_code", int'(reject_code), 0);
        chk("t7_vv", int'(vote_valid), 0);
        chk("t7_rj", int'(reject_pulse), 0);
        ticks(2);
        rst = 1'b0;
        last_code = 0;
        snap();
        ticks(30);
        chk("t7_post_vv", n_vv - b_vv, 0);
        chk("t7_post_rj", n_rj - b_rj, 0);
        chk("t7_post_fin", n_fin - b_fin, 0);
        chk("t7_post_clr", n_clr - b_clr, 0);
        chk("t7_post_busy", n_busy - b_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
